// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
//
// Purpose:
//   Groups the signals exchanged between the pipeline datapath and the
//   stall/flush scheduler (hazard_ctrl).
//
// Signal summary:
//   Hazard inputs (driven by the pipeline, read by hazard_ctrl):
//     idexMemRdEnable   instruction in EX is a load
//     idexRDOut[4:0]    destination register of instruction in EX
//     ifidRSOut[4:0]    rs of instruction in ID
//     ifidRTOut[4:0]    rt of instruction in ID
//     ifidUseRS         instruction in ID reads rs
//     ifidUseRT         instruction in ID reads rt
//     exBrTaken         branch/jump in EX resolved taken
//     exMdStart         instruction in EX is a mul/div
//   Pipeline controls (driven by hazard_ctrl, read by the pipeline):
//     pcWrEnable        PC update enable
//     ifidWrEnable      IF/ID load enable
//     ifidFlush         IF/ID loads NOP
//     idexWrEnable      ID/EX load enable
//     idexBubble        ID/EX loads NOP
//     exmemBubble       EX/MEM loads NOP
//     mdBusy            mul/div sequence in progress
//     mdDone            mul/div result valid, one cycle
//
// Modports:
//   master  pipeline side (drives hazard inputs, receives controls)
//   slave   hazard_ctrl side
// -----------------------------------------------------------------------------
interface hazard_ctrl_if;

  // Hazard inputs
  logic       idexMemRdEnable;
  logic [4:0] idexRDOut;
  logic [4:0] ifidRSOut;
  logic [4:0] ifidRTOut;
  logic       ifidUseRS;
  logic       ifidUseRT;
  logic       exBrTaken;
  logic       exMdStart;

  // Pipeline controls
  logic       pcWrEnable;
  logic       ifidWrEnable;
  logic       ifidFlush;
  logic       idexWrEnable;
  logic       idexBubble;
  logic       exmemBubble;
  logic       mdBusy;
  logic       mdDone;

  modport master (
    output idexMemRdEnable, idexRDOut, ifidRSOut, ifidRTOut,
           ifidUseRS, ifidUseRT, exBrTaken, exMdStart,
    input  pcWrEnable, ifidWrEnable, ifidFlush, idexWrEnable,
           idexBubble, exmemBubble, mdBusy, mdDone
  );

  modport slave (
    input  idexMemRdEnable, idexRDOut, ifidRSOut, ifidRTOut,
           ifidUseRS, ifidUseRT, exBrTaken, exMdStart,
    output pcWrEnable, ifidWrEnable, ifidFlush, idexWrEnable,
           idexBubble, exmemBubble, mdBusy, mdDone
  );

endinterface : hazard_ctrl_if

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Purpose:
//   Stall/flush scheduler for the 5-stage core. Sits beside the forwarding
//   unit and resolves the hazards forwarding cannot cover:
//     - load-use: a load in EX whose destination is read by the ID
//       instruction -> one-cycle stall of PC and IF/ID, bubble into ID/EX.
//     - multi-cycle mul/div in EX -> whole front end frozen for MD_LATENCY
//       cycles, bubbles into EX/MEM, then a one-cycle mdDone.
//     - taken branch in EX -> IF/ID flushed and bubble into ID/EX.
//   Priority, highest first: mul/div stall > branch flush > load-use.
//
// Parameters:
//   MD_LATENCY  total stalled cycles for a mul/div in EX (2..15)
//   CNT_WIDTH   countdown counter width; must hold MD_LATENCY-2
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-low reset
//   hz     hazard_ctrl_if.slave (hazard inputs, pipeline controls)
//   luStallCount[31:0], mdStallCount[31:0]
//          saturating performance counters, present only when the
//          HAZARD_PERF_CNT_EN macro is defined
//
// Outputs are combinational from the FSM state and the current inputs; the
// FSM state and the countdown counter (plus the optional perf counters) are
// the only storage.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int MD_LATENCY = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]  luStallCount,
  output logic [31:0]  mdStallCount
`endif
);

  // ---------------------------------------------------------------------------
  // Mul/div sequencer state
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdState_t;

  localparam logic [CNT_WIDTH-1:0] MD_LOAD = CNT_WIDTH'(MD_LATENCY - 2);

  mdState_t             mdState;
  logic [CNT_WIDTH-1:0] mdCount;

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  logic rsHit;
  logic rtHit;
  logic loadUse;   // raw load-use condition, before priority
  logic mdStart;   // new mul/div accepted this cycle (IDLE only)
  logic mdStall;   // front end frozen by the mul/div sequencer
  logic luStall;   // load-use stall that actually takes effect

  // Register 0 is hard-wired zero, so a load targeting it never creates a
  // dependency.
  assign rsHit   = hz.ifidUseRS && (hz.ifidRSOut == hz.idexRDOut);
  assign rtHit   = hz.ifidUseRT && (hz.ifidRTOut == hz.idexRDOut);
  assign loadUse = hz.idexMemRdEnable && (hz.idexRDOut != 5'd0) && (rsHit || rtHit);

  // exMdStart is only meaningful in IDLE: while BUSY/DONE the same mul/div is
  // still sitting in EX and must not restart the sequence.
  assign mdStart = (mdState == IDLE) && hz.exMdStart;
  assign mdStall = mdStart || (mdState == BUSY);

  // A taken branch squashes the ID instruction anyway, so the load-use stall
  // it would have needed is pointless; the mul/div freeze beats both.
  assign luStall = loadUse && !mdStall && !hz.exBrTaken;

  // ---------------------------------------------------------------------------
  // Pipeline control outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default before any branch so no path leaves
    // it unassigned; that is what keeps this block free of inferred latches.
    hz.pcWrEnable   = 1'b1;
    hz.ifidWrEnable = 1'b1;
    hz.idexWrEnable = 1'b1;
    hz.ifidFlush    = 1'b0;
    hz.idexBubble   = 1'b0;
    hz.exmemBubble  = 1'b0;
    hz.mdBusy       = 1'b0;
    hz.mdDone       = 1'b0;

    // While reset is asserted the defaults hold regardless of the inputs.
    if (rst) begin
      if (mdStall) begin
        // Freeze PC, IF/ID and ID/EX; EX/MEM receives bubbles while the
        // mul/div occupies EX.
        hz.pcWrEnable   = 1'b0;
        hz.ifidWrEnable = 1'b0;
        hz.idexWrEnable = 1'b0;
        hz.exmemBubble  = 1'b1;
        hz.mdBusy       = 1'b1;
      end else begin
        hz.mdDone = (mdState == DONE);
        if (hz.exBrTaken) begin
          // Wrong-path instructions in IF and ID are squashed; fetch keeps
          // going from the branch target.
          hz.ifidFlush  = 1'b1;
          hz.idexBubble = 1'b1;
        end else if (luStall) begin
          // Hold the dependent instruction in ID for one cycle; the load
          // leaves EX at the next edge and forwarding covers it from MEM.
          hz.pcWrEnable   = 1'b0;
          hz.ifidWrEnable = 1'b0;
          hz.idexBubble   = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Mul/div FSM
  //
  // Timeline for MD_LATENCY = N: start cycle (IDLE, stall) loads N-2, then
  // BUSY counts N-2 .. 0 (N-1 more stall cycles), then one DONE cycle.
  // That gives N stalled cycles and mdDone exactly N cycles after start.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mdState <= IDLE;
      mdCount <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      case (mdState)
        IDLE: begin
          if (hz.exMdStart) begin
            mdState <= BUSY;
            mdCount <= MD_LOAD;
          end
        end
        BUSY: begin
          if (mdCount == '0) begin
            mdState <= DONE;
          end else begin
            mdCount <= mdCount - CNT_WIDTH'(1);
          end
        end
        DONE: begin
          mdState <= IDLE;
        end
        default: begin
          mdState <= IDLE;
          mdCount <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Saturating stall counters: they stick at all-ones rather than wrap so a
  // long run never reports a misleadingly small number.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      luStallCount <= '0;
      mdStallCount <= '0;
    end else begin
      if (luStall && (luStallCount != '1)) begin
        luStallCount <= luStallCount + 32'd1;
      end
      if (mdStall && (mdStallCount != '1)) begin
        mdStallCount <= mdStallCount + 32'd1;
      end
    end
  end
`endif

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Self-checking bench for hazard_ctrl: a table of single-cycle vectors in
// IDLE, hand-written multi-cycle sequences (mul/div timing, held start,
// priority during BUSY, reset mid-sequence), then randomized stimulus
// checked against a cycle-position reference model. Build with
// HAZARD_PERF_CNT_EN defined to also check the stall counters.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int L = 8;

  // Output vector order: pc, ifidWr, ifidFlush, idexWr, idexBubble,
  // exmemBubble, mdBusy, mdDone
  localparam logic [7:0] O_DEF  = 8'hD0;
  localparam logic [7:0] O_LU   = 8'h18;
  localparam logic [7:0] O_BR   = 8'hF8;
  localparam logic [7:0] O_MD   = 8'h06;
  localparam logic [7:0] O_DONE = 8'hD1;

  typedef struct packed {
    logic       memRd;
    logic [4:0] rd;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       useRs;
    logic       useRt;
    logic       br;
    logic       start;
  } inVec_t;

  typedef struct {
    string      name;
    inVec_t     in;
    logic [7:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if hz ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] luStallCount;
  logic [31:0] mdStallCount;
`endif

  hazard_ctrl #(.MD_LATENCY(L), .CNT_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .luStallCount (luStallCount),
    .mdStallCount (mdStallCount)
`endif
  );

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] outVec();
    return {hz.pcWrEnable, hz.ifidWrEnable, hz.ifidFlush, hz.idexWrEnable,
            hz.idexBubble, hz.exmemBubble, hz.mdBusy, hz.mdDone};
  endfunction

  function automatic inVec_t mkIn(input logic memRd, input int rd, input int rs,
                                  input int rt, input logic useRs, input logic useRt,
                                  input logic br, input logic start);
    inVec_t v;
    v.memRd = memRd; v.rd = 5'(rd); v.rs = 5'(rs); v.rt = 5'(rt);
    v.useRs = useRs; v.useRt = useRt; v.br = br; v.start = start;
    return v;
  endfunction

  task automatic drive(input inVec_t v);
    hz.idexMemRdEnable = v.memRd;
    hz.idexRDOut       = v.rd;
    hz.ifidRSOut       = v.rs;
    hz.ifidRTOut       = v.rt;
    hz.ifidUseRS       = v.useRs;
    hz.ifidUseRT       = v.useRt;
    hz.exBrTaken       = v.br;
    hz.exMdStart       = v.start;
  endtask

  // One cycle: drive just after the rising edge, sample mid-cycle.
  task automatic stepCheck(input string name, input inVec_t v, input logic [7:0] exp);
    @(posedge clk);
    #1 drive(v);
    #3 check(name, 32'(outVec()), 32'(exp));
  endtask

  task automatic doReset();
    @(posedge clk);
    #1 rst = 1'b0;
    drive('0);
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: mdPos is the number of cycles since the accepted start
  // (-1 when no sequence is in flight). Cycles 0..L-1 stall, cycle L is done.
  // ---------------------------------------------------------------------------
  int mdPos   = -1;
  int modelLu = 0;
  int modelMd = 0;

  function automatic logic [7:0] modelOut(input int pos, input inVec_t v, output logic luEff);
    logic lu;
    logic [7:0] o;
    lu = v.memRd && (v.rd != 0) &&
         ((v.useRs && v.rs == v.rd) || (v.useRt && v.rt == v.rd));
    luEff = 1'b0;
    if (pos >= 0 && pos < L) return O_MD;
    o = (pos == L) ? O_DONE : O_DEF;
    if (v.br) begin
      o[5] = 1'b1; o[3] = 1'b1;
    end else if (lu) begin
      o[7] = 1'b0; o[6] = 1'b0; o[3] = 1'b1;
      luEff = 1'b1;
    end
    return o;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  vec_t table_q[$];

  initial begin
    drive('0);
    rst = 1'b0;

    // --- Reset forces defaults regardless of inputs ---
    #2 drive(mkIn(1, 5, 5, 5, 1, 1, 1, 1));
    #1 check("reset_forces_defaults", 32'(outVec()), 32'(O_DEF));
    @(posedge clk);
    #1 rst = 1'b1;
    drive('0);

    // --- Table of single-cycle vectors in IDLE ---
    table_q.push_back('{"idle_default",      mkIn(0, 0, 0, 0, 0, 0, 0, 0), O_DEF});
    table_q.push_back('{"lu_rs",             mkIn(1, 5, 5, 0, 1, 0, 0, 0), O_LU});
    table_q.push_back('{"lu_released",       mkIn(0, 5, 5, 0, 1, 0, 0, 0), O_DEF});
    table_q.push_back('{"lu_rd_zero",        mkIn(1, 0, 0, 0, 1, 1, 0, 0), O_DEF});
    table_q.push_back('{"lu_rt",             mkIn(1, 7, 1, 7, 0, 1, 0, 0), O_LU});
    table_q.push_back('{"rt_match_unused",   mkIn(1, 7, 1, 7, 1, 0, 0, 0), O_DEF});
    table_q.push_back('{"rs_match_unused",   mkIn(1, 9, 9, 3, 0, 1, 0, 0), O_DEF});
    table_q.push_back('{"rt_used_rs_not",    mkIn(1, 9, 9, 9, 0, 1, 0, 0), O_LU});
    table_q.push_back('{"no_load_match",     mkIn(0, 4, 4, 4, 1, 1, 0, 0), O_DEF});
    table_q.push_back('{"branch_only",       mkIn(0, 0, 0, 0, 0, 0, 1, 0), O_BR});
    table_q.push_back('{"branch_beats_lu",   mkIn(1, 5, 5, 0, 1, 0, 1, 0), O_BR});
    table_q.push_back('{"reg_mismatch",      mkIn(1, 3, 4, 5, 1, 1, 0, 0), O_DEF});
    table_q.push_back('{"lu_rd31",           mkIn(1, 31, 2, 31, 1, 1, 0, 0), O_LU});
    foreach (table_q[i]) stepCheck(table_q[i].name, table_q[i].in, table_q[i].exp);

    // --- Mul/div single pulse: stall 0..L-1, done at L, default at L+1 ---
    stepCheck("md_pulse_c0", mkIn(0, 0, 0, 0, 0, 0, 0, 1), O_MD);
    for (int c = 1; c <= L + 1; c++) begin
      stepCheck($sformatf("md_pulse_c%0d", c), '0,
                (c < L) ? O_MD : (c == L) ? O_DONE : O_DEF);
    end

    // --- Start held through cycle L, with branch/LU during BUSY ignored ---
    for (int c = 0; c <= L + 1; c++) begin
      inVec_t v;
      v = mkIn(1, 6, 6, 0, 1, 0, (c >= 2 && c <= 4), (c <= L));
      if (c > 4) v.br = 1'b0;
      if (c == L) v.memRd = 1'b0;   // DONE cycle: no other hazard present
      stepCheck($sformatf("md_held_c%0d", c), v,
                (c < L) ? O_MD : (c == L) ? O_DONE : O_LU);
    end

    // --- LU in DONE gives one stall cycle, mdDone still pulses ---
    stepCheck("md_lu_c0", mkIn(0, 0, 0, 0, 0, 0, 0, 1), O_MD);
    for (int c = 1; c < L; c++) stepCheck($sformatf("md_lu_c%0d", c), '0, O_MD);
    stepCheck("md_lu_done", mkIn(1, 2, 2, 0, 1, 0, 0, 0), 8'h19);
    stepCheck("md_lu_after", '0, O_DEF);

    // --- MD start and branch together in IDLE: MD wins ---
    stepCheck("md_beats_branch", mkIn(0, 0, 0, 0, 0, 0, 1, 1), O_MD);
    for (int c = 1; c <= L; c++) stepCheck($sformatf("mdbr_c%0d", c), '0,
                                             (c < L) ? O_MD : O_DONE);

    // --- Reset mid-BUSY at counter 3 (cycle 4) ---
    stepCheck("rst_mid_c0", mkIn(0, 0, 0, 0, 0, 0, 0, 1), O_MD);
    for (int c = 1; c <= 4; c++) stepCheck($sformatf("rst_mid_c%0d", c), '0, O_MD);
    #1 rst = 1'b0;
    #1 check("rst_mid_immediate", 32'(outVec()), 32'(O_DEF));
    drive(mkIn(1, 5, 5, 5, 1, 1, 1, 1));
    @(posedge clk);
    #2 check("rst_mid_held", 32'(outVec()), 32'(O_DEF));
    drive('0);
    #1 rst = 1'b1;
    #1 check("rst_mid_released", 32'(outVec()), 32'(O_DEF));
    for (int c = 0; c < L + 2; c++) stepCheck($sformatf("rst_no_done_c%0d", c), '0, O_DEF);
    stepCheck("rst_restart_c0", mkIn(0, 0, 0, 0, 0, 0, 0, 1), O_MD);
    for (int c = 1; c <= L + 1; c++) begin
      stepCheck($sformatf("rst_restart_c%0d", c), '0,
                (c < L) ? O_MD : (c == L) ? O_DONE : O_DEF);
    end

`ifdef HAZARD_PERF_CNT_EN
    // --- Perf counters: 2 LU stalls + one mul/div ---
    doReset();
    #3 check("perf_lu_reset", luStallCount, 32'd0);
    check("perf_md_reset", mdStallCount, 32'd0);
    stepCheck("perf_lu1", mkIn(1, 5, 5, 0, 1, 0, 0, 0), O_LU);
    stepCheck("perf_lu_br", mkIn(1, 5, 5, 0, 1, 0, 1, 0), O_BR);
    stepCheck("perf_lu2", mkIn(1, 8, 0, 8, 0, 1, 0, 0), O_LU);
    stepCheck("perf_md_c0", mkIn(0, 0, 0, 0, 0, 0, 0, 1), O_MD);
    for (int c = 1; c <= L + 1; c++) begin
      stepCheck($sformatf("perf_md_c%0d", c), mkIn(1, 5, 5, 0, 1, 0, 0, 0),
                (c < L) ? O_MD : (c == L) ? 8'h19 : O_LU);
    end
    check("perf_lu_count", luStallCount, 32'd4);
    check("perf_md_count", mdStallCount, 32'(L));
`endif

    // --- Randomized run against the reference model ---
    doReset();
    mdPos   = -1;
    modelLu = 0;
    modelMd = 0;
    for (int n = 0; n < 3000; n++) begin
      inVec_t v;
      int pos;
      logic luEff;
      logic [7:0] exp;
      v.memRd = 1'($urandom_range(0, 1));
      v.rd    = 5'($urandom_range(0, 3));
      v.rs    = 5'($urandom_range(0, 3));
      v.rt    = 5'($urandom_range(0, 3));
      v.useRs = 1'($urandom_range(0, 1));
      v.useRt = 1'($urandom_range(0, 1));
      v.br    = ($urandom_range(0, 5) == 0);
      v.start = ($urandom_range(0, 7) == 0);
      pos = (mdPos < 0 && v.start) ? 0 : mdPos;
      exp = modelOut(pos, v, luEff);
      stepCheck($sformatf("rand_%0d", n), v, exp);
      if (luEff) modelLu++;
      if (pos >= 0 && pos < L) modelMd++;
      mdPos = (pos < 0 || pos == L) ? -1 : pos + 1;
    end
`ifdef HAZARD_PERF_CNT_EN
    @(posedge clk);
    #1 drive('0);
    check("rand_lu_count", luStallCount, 32'(modelLu));
    check("rand_md_count", mdStallCount, 32'(modelMd));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_hazard_ctrl

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline stall/flush scheduler for the 5-stage core.
- Detects load-use hazards that forwarding cannot cover.
- Sequences the multi-cycle mul/div unit occupying EX.
- Squashes wrong-path instructions on a taken branch.
- Drives the write-enable and bubble controls of the PC, IF/ID, ID/EX and EX/MEM registers; sits beside the forwarding unit.

Parameters:
- MD_LATENCY, 8, total stalled cycles for a mul/div in EX; legal range 2..15.
- CNT_WIDTH, 4, width of the mul/div countdown counter; must hold MD_LATENCY-2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- idexMemRdEnable  in  1  instruction in EX is a load.
- idexRDOut  in  5  destination register of instruction in EX.
- ifidRSOut  in  5  rs of instruction in ID.
- ifidRTOut  in  5  rt of instruction in ID.
- ifidUseRS  in  1  instruction in ID reads rs.
- ifidUseRT  in  1  instruction in ID reads rt.
- exBrTaken  in  1  branch/jump in EX resolved taken.
- exMdStart  in  1  instruction in EX is a mul/div.
- pcWrEnable  out  1  PC update enable.
- ifidWrEnable  out  1  IF/ID load enable.
- ifidFlush  out  1  IF/ID loads NOP.
- idexWrEnable  out  1  ID/EX load enable.
- idexBubble  out  1  ID/EX loads NOP.
- exmemBubble  out  1  EX/MEM loads NOP.
- mdBusy  out  1  mul/div sequence in progress.
- mdDone  out  1  mul/div result valid; one cycle.

Behaviour:
- Outputs are combinational from FSM state and inputs. The FSM and counter are the only state.
- Reset (rst=0, async): state IDLE, counter 0.
  - Write enables forced 1; ifidFlush, idexBubble, exmemBubble, mdBusy and mdDone forced 0, regardless of inputs.
- Default, no event: pcWrEnable=1, ifidWrEnable=1, idexWrEnable=1, all others 0.
- Load-use condition LU:
  - idexMemRdEnable && idexRDOut!=0 && ((ifidUseRS && ifidRSOut==idexRDOut) || (ifidUseRT && ifidRTOut==idexRDOut)).
  - Response: pcWrEnable=0, ifidWrEnable=0, idexBubble=1 for that cycle. Exactly one stall cycle per hazard, since the load leaves EX next edge.
- Mul/div FSM, states IDLE / BUSY / DONE:
  - IDLE and exMdStart=1: stall this cycle (pcWrEnable=0, ifidWrEnable=0, idexWrEnable=0, exmemBubble=1, mdBusy=1). Load counter with MD_LATENCY-2; go to BUSY.
  - BUSY: same stall outputs, mdBusy=1. If counter==0, go to DONE; else decrement.
  - DONE: no stall, mdDone=1, mdBusy=0; go to IDLE.
  - Total stalled cycles = MD_LATENCY; mdDone rises exactly MD_LATENCY cycles after the start cycle.
- exMdStart is accepted only in IDLE.
  - In BUSY/DONE it is ignored; the same instruction is still in EX.
  - Back-to-back mul/div: the second one enters EX after DONE and is seen in IDLE.
- Taken branch (exBrTaken=1, not stalled by the FSM): ifidFlush=1, idexBubble=1; PC/IF/ID write enables stay 1.
- Priority, highest first: FSM stall (start/BUSY) > branch flush > LU.
  - exBrTaken and LU in BUSY are ignored.
  - exBrTaken with LU in IDLE: flush only, pcWrEnable=1, ifidWrEnable=1 (the ID instruction is squashed).
  - exMdStart with exBrTaken in IDLE: MD start wins and the branch is ignored that cycle.
- LU in DONE: handled normally, one stall cycle.
- Reset asserted mid-BUSY: immediate IDLE, counter 0; no mdDone pulse.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds outputs luStallCount[31:0] and mdStallCount[31:0].
  - Reset to 0.
  - luStallCount increments on each cycle LU actually stalls (LU active and not overridden).
  - mdStallCount increments on each FSM stall cycle.
  - Both saturate at 0xFFFFFFFF.
- Undefined: ports and counters absent; no other behaviour change.

Test Plan:
- Load-use: idexMemRdEnable=1, idexRDOut=5, ifidRSOut=5, ifidUseRS=1, one cycle -> pcWrEnable=0, ifidWrEnable=0, idexBubble=1 that cycle only. Repeat with idexRDOut=0 -> no stall.
- Mul/div, MD_LATENCY=8: pulse exMdStart at cycle 0 -> stall outputs and mdBusy=1 on cycles 0..7; mdDone=1 on cycle 8; defaults on cycle 9. exMdStart held through cycle 8 -> no second sequence.
- Branch: exBrTaken=1 with LU also true -> ifidFlush=1, idexBubble=1, pcWrEnable=1, ifidWrEnable=1.
- Priority: exMdStart=1 and exBrTaken=1 in IDLE -> MD stall, ifidFlush=0. exBrTaken=1 during BUSY -> ifidFlush=0.
- Reset mid-op: rst=0 at BUSY counter=3 -> outputs at defaults immediately, no mdDone. After release, exMdStart runs a full 8-cycle sequence.
- Macro defined: 2 LU stalls + one 8-cycle mul/div -> luStallCount=2, mdStallCount=8. Preloaded counter at 0xFFFFFFFF stays saturated.
